// File: rtl/tl_scratchpad_responder.sv
// Single-beat TileLink-UL scratchpad: byte-lane block RAM behind a one-entry response register.
// Optional macro TL_SCRATCHPAD_RANGE_CHECK_EN denies requests outside [BASE_ADDR, BASE_ADDR+DEPTH*8).
module tl_scratchpad_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [1:0]  auto_in_a_bits_size,
    input  logic [9:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [1:0]  auto_in_d_bits_size,
    output logic [9:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);
    localparam int         IDX_W          = $clog2(DEPTH);
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] D_ACK          = 3'd0;
    localparam logic [2:0] D_ACK_DATA     = 3'd1;

    logic             d_valid_reg;
    logic             d_valid_next;
    logic [2:0]       d_opcode_reg;
    logic [1:0]       d_size_reg;
    logic [9:0]       d_source_reg;
    logic             d_denied_reg;
    logic             d_corrupt_reg;
    logic             d_data_sel_reg;
    logic [63:0]      rd_data;

    logic             a_fire;
    logic             d_fire;
    logic             is_put;
    logic             is_get;
    logic             in_range;
    logic             req_denied;
    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] idx;
    logic             unused_bits;

    assign auto_in_a_ready = !d_valid_reg || auto_in_d_ready;
    assign a_fire          = auto_in_a_valid && auto_in_a_ready;
    assign d_fire          = d_valid_reg && auto_in_d_ready;

    assign idx    = auto_in_a_bits_address[3 +: IDX_W];
    assign is_put = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                    (auto_in_a_bits_opcode == OP_PUT_PARTIAL);
    assign is_get = (auto_in_a_bits_opcode == OP_GET);

`ifdef TL_SCRATCHPAD_RANGE_CHECK_EN
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd8;
    logic [31:0] addr_offset;
    assign addr_offset = auto_in_a_bits_address - BASE_ADDR;
    assign in_range    = ({1'b0, addr_offset} < SPAN);
`else
    // Upper address bits simply alias onto the word index.
    assign in_range = 1'b1;
`endif

    assign req_denied = !(is_put || is_get) || !in_range;
    assign wr_en      = a_fire && is_put && in_range && !reset;
    assign rd_en      = a_fire && is_get && in_range && !reset;

    assign unused_bits = ^{auto_in_a_bits_param, auto_in_a_bits_address, BASE_ADDR};

    // One byte-wide RAM per lane keeps the byte-enable write inferable.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (wr_en && auto_in_a_bits_mask[gi]) begin
                    lane_mem[idx] <= auto_in_a_bits_data[8*gi +: 8];
                end
                if (reset) begin
                    rd_byte_reg <= '0;
                end else if (rd_en) begin
                    rd_byte_reg <= lane_mem[idx];
                end
            end

            assign rd_data[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_comb begin
        d_valid_next = d_valid_reg;
        if (a_fire) begin
            d_valid_next = 1'b1;
        end else if (d_fire) begin
            d_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid_reg    <= 1'b0;
            d_opcode_reg   <= D_ACK;
            d_size_reg     <= '0;
            d_source_reg   <= '0;
            d_denied_reg   <= 1'b0;
            d_corrupt_reg  <= 1'b0;
            d_data_sel_reg <= 1'b0;
        end else begin
            d_valid_reg <= d_valid_next;
            if (a_fire) begin
                d_opcode_reg   <= is_get ? D_ACK_DATA : D_ACK;
                d_size_reg     <= auto_in_a_bits_size;
                d_source_reg   <= auto_in_a_bits_source;
                d_denied_reg   <= req_denied;
                d_corrupt_reg  <= is_get && req_denied;
                d_data_sel_reg <= is_get && !req_denied;
            end
        end
    end

    // The RAM output register only moves on an accepted Get, so data stays stable while stalled.
    assign auto_in_d_valid        = d_valid_reg;
    assign auto_in_d_bits_opcode  = d_opcode_reg;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = d_size_reg;
    assign auto_in_d_bits_source  = d_source_reg;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = d_denied_reg;
    assign auto_in_d_bits_corrupt = d_corrupt_reg;
    assign auto_in_d_bits_data    = d_data_sel_reg ? rd_data : 64'd0;

endmodule

// File: tb/tb_tl_scratchpad_responder.sv
// Directed bench for tl_scratchpad_responder; honours TL_SCRATCHPAD_RANGE_CHECK_EN when defined.
module tb_tl_scratchpad_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_ready;
    logic        a_valid = 1'b0;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [1:0]  a_size = '0;
    logic [9:0]  a_source = '0;
    logic [31:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        d_ready = 1'b1;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [9:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    tl_scratchpad_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request for exactly one clock edge; returns #1 after that edge.
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic [1:0] size, input logic [9:0] src);
        @(negedge clock);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_size    = size;
        a_source  = src;
        d_ready   = 1'b1;
        @(posedge clock);
        #1;
        a_valid = 1'b0;
        $display("req op=%0d addr=%h mask=%h src=%0d -> d op=%0d src=%0d den=%0d cor=%0d data=%h",
                 op, addr, mask, src, d_opcode, d_source, d_denied, d_corrupt, d_data);
    endtask

    task automatic expect_resp(input string tag, input logic [2:0] op, input logic [9:0] src,
                               input logic [1:0] size, input logic den, input logic cor,
                               input logic [63:0] data);
        check_val({tag, ".valid"},   d_valid,   1);
        check_val({tag, ".opcode"},  d_opcode,  op);
        check_val({tag, ".source"},  d_source,  src);
        check_val({tag, ".size"},    d_size,    size);
        check_val({tag, ".denied"},  d_denied,  den);
        check_val({tag, ".corrupt"}, d_corrupt, cor);
        check_val({tag, ".data"},    d_data,    data);
        check_val({tag, ".param"},   d_param,   0);
        check_val({tag, ".sink"},    d_sink,    0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_val("rst.d_valid", d_valid, 0);
        check_val("rst.a_ready", a_ready, 1);
        check_val("rst.opcode",  d_opcode, 0);
        check_val("rst.source",  d_source, 0);
        check_val("rst.data",    d_data, 0);
        @(negedge clock);
        reset = 1'b0;

        send(3'd0, 32'h10, 8'hFF, 64'hDEADBEEF_CAFEF00D, 2'd3, 10'd5);
        expect_resp("putfull", 3'd0, 10'd5, 2'd3, 1'b0, 1'b0, 64'h0);
        send(3'd4, 32'h10, 8'hFF, 64'h0, 2'd3, 10'd7);
        expect_resp("get", 3'd1, 10'd7, 2'd3, 1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D);

        send(3'd1, 32'h10, 8'h0F, 64'h11111111_22222222, 2'd3, 10'd1);
        expect_resp("putpart", 3'd0, 10'd1, 2'd3, 1'b0, 1'b0, 64'h0);
        send(3'd4, 32'h10, 8'h01, 64'h0, 2'd0, 10'd2);
        expect_resp("getmask", 3'd1, 10'd2, 2'd0, 1'b0, 1'b0, 64'hDEADBEEF_22222222);
        send(3'd4, 32'h17, 8'hFF, 64'h0, 2'd3, 10'd3);
        expect_resp("getlowbits", 3'd1, 10'd3, 2'd3, 1'b0, 1'b0, 64'hDEADBEEF_22222222);

        // Sparse lanes 0,2,5,7 over a zeroed word.
        send(3'd0, 32'h18, 8'hFF, 64'h0, 2'd3, 10'd4);
        send(3'd1, 32'h18, 8'hA5, 64'h88776655_44332211, 2'd3, 10'd4);
        send(3'd4, 32'h18, 8'hFF, 64'h0, 2'd3, 10'd6);
        expect_resp("sparse", 3'd1, 10'd6, 2'd3, 1'b0, 1'b0, 64'h88006600_00330011);

        // Get accepted the very next cycle after a Put to the same word.
        send(3'd0, 32'h20, 8'hFF, 64'h0F1E2D3C_4B5A6978, 2'd3, 10'd8);
        send(3'd4, 32'h20, 8'hFF, 64'h0, 2'd3, 10'd9);
        expect_resp("rawfwd", 3'd1, 10'd9, 2'd3, 1'b0, 1'b0, 64'h0F1E2D3C_4B5A6978);

        send(3'd6, 32'h10, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 2'd3, 10'd10);
        expect_resp("op6", 3'd0, 10'd10, 2'd3, 1'b1, 1'b0, 64'h0);
        send(3'd2, 32'h10, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 2'd2, 10'd11);
        expect_resp("op2", 3'd0, 10'd11, 2'd2, 1'b1, 1'b0, 64'h0);
        send(3'd4, 32'h10, 8'hFF, 64'h0, 2'd3, 10'd12);
        expect_resp("illegalkeep", 3'd1, 10'd12, 2'd3, 1'b0, 1'b0, 64'hDEADBEEF_22222222);

        send(3'd0, 32'h0, 8'hFF, 64'h01234567_89ABCDEF, 2'd3, 10'd13);
        send(3'd4, 32'h800, 8'hFF, 64'h0, 2'd3, 10'd14);
`ifdef TL_SCRATCHPAD_RANGE_CHECK_EN
        expect_resp("oorget", 3'd1, 10'd14, 2'd3, 1'b1, 1'b1, 64'h0);
`else
        expect_resp("oorget", 3'd1, 10'd14, 2'd3, 1'b0, 1'b0, 64'h01234567_89ABCDEF);
`endif
        send(3'd0, 32'h800, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 2'd3, 10'd15);
        send(3'd4, 32'h0, 8'hFF, 64'h0, 2'd3, 10'd16);
`ifdef TL_SCRATCHPAD_RANGE_CHECK_EN
        expect_resp("oorput", 3'd1, 10'd16, 2'd3, 1'b0, 1'b0, 64'h01234567_89ABCDEF);
`else
        expect_resp("oorput", 3'd1, 10'd16, 2'd3, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFF);
`endif

        // Backpressure: response held, a competing Get must wait.
        send(3'd4, 32'h10, 8'hFF, 64'h0, 2'd3, 10'd20);
        d_ready   = 1'b0;
        a_valid   = 1'b1;
        a_opcode  = 3'd4;
        a_address = 32'h20;
        a_source  = 10'd21;
        a_size    = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check_val($sformatf("stall%0d.a_ready", i), a_ready, 0);
            check_val($sformatf("stall%0d.d_valid", i), d_valid, 1);
            check_val($sformatf("stall%0d.source", i), d_source, 20);
            check_val($sformatf("stall%0d.data", i), d_data, 64'hDEADBEEF_22222222);
        end
        @(negedge clock);
        d_ready = 1'b1;
        #1;
        check_val("release.a_ready", a_ready, 1);
        @(posedge clock);
        #1;
        a_valid = 1'b0;
        expect_resp("b2b", 3'd1, 10'd21, 2'd3, 1'b0, 1'b0, 64'h0F1E2D3C_4B5A6978);
        @(posedge clock);
        #1;
        check_val("drain.d_valid", d_valid, 0);

        // Reset discards a pending response.
        send(3'd4, 32'h10, 8'hFF, 64'h0, 2'd3, 10'd30);
        d_ready = 1'b0;
        check_val("prerst.d_valid", d_valid, 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_val("midrst.d_valid", d_valid, 0);
        check_val("midrst.a_ready", a_ready, 1);
        @(negedge clock);
        reset   = 1'b0;
        d_ready = 1'b1;
        send(3'd6, 32'h10, 8'hFF, 64'h12345678_12345678, 2'd3, 10'd31);
        expect_resp("postrst.op6", 3'd0, 10'd31, 2'd3, 1'b1, 1'b0, 64'h0);
        send(3'd4, 32'h10, 8'hFF, 64'h0, 2'd3, 10'd32);
        expect_resp("postrst.get", 3'd1, 10'd32, 2'd3, 1'b0, 1'b0, 64'hDEADBEEF_22222222);
        @(posedge clock);
        #1;
        check_val("final.d_valid", d_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
